apb_uart_ng: RTL and testbench

APB_UART_NG -- requirements
Module: apb_uart_ng

---
 rtl/apb_uart_ng_pkg.sv | 55 +++++
 rtl/uart_sync_fifo.sv | 59 +++++
 rtl/apb_uart_ng.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_apb_uart_ng.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_uart_ng_pkg.sv
// Shared register map, CTRL/STATUS bit positions, parity encoding and
// serial FSM state types for the APB UART.
package apb_uart_ng_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_SCALER = 2'd3;

  localparam int CTRL_W     = 9;
  localparam int CTRL_RE    = 0;
  localparam int CTRL_TEN   = 1;
  localparam int CTRL_PAR   = 2;
  localparam int CTRL_STOP2 = 4;
  localparam int CTRL_RIE   = 5;
  localparam int CTRL_TIE   = 6;
  localparam int CTRL_EIE   = 7;
  localparam int CTRL_LB    = 8;

  localparam int ST_DR    = 0;
  localparam int ST_TS    = 1;
  localparam int ST_TE    = 2;
  localparam int ST_TF    = 3;
  localparam int ST_RF    = 4;
  localparam int ST_OV    = 5;
  localparam int ST_PE    = 6;
  localparam int ST_FE    = 7;
  localparam int ST_RXCNT = 8;
  localparam int ST_TXCNT = 16;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_ODD   = 2'b10,
    PAR_NONE3 = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  function automatic logic par_enabled(input parity_e mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Parity bit that makes the total count of ones even (or odd).
  function automatic logic par_bit(input parity_e mode, input logic data_xor);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop frees the slot a same-cycle
// push reuses, so push+pop while full keeps every entry.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/apb_uart_ng.sv
// APB-attached UART: DATA/STATUS/CTRL/SCALER registers, TX and RX FIFOs,
// serial transmitter and receiver with parity, stop-bit and loopback options.
module apb_uart_ng
  import apb_uart_ng_pkg::*;
#(
  parameter int               DATA_BITS  = 8,
  parameter int               FIFO_DEPTH = 16,
  parameter int               SBITS      = 12,
  parameter int               ABITS      = 8,
  parameter logic [SBITS-1:0] SCALER_RST = 12'd867
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             psel,
  input  logic             penable,
  input  logic [ABITS-1:0] paddr,
  input  logic             pwrite,
  input  logic [31:0]      pwdata,
  output logic [31:0]      prdata,
  output logic             pready,
  output logic             pslverr,
  input  logic             rxd,
  output logic             txd,
  output logic             irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [SBITS-1:0]  scaler_q, scaler_d;
  logic ov_q, ov_d, pe_q, pe_d, fe_q, fe_d, irq_q, irq_d;

  logic access, wr_data, rd_data, wr_status;
  logic [1:0] sel;
  logic [31:0] status;

  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_BITS-1:0] tx_rdata;
  logic [CW-1:0]        tx_count;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_BITS-1:0] rx_rdata;
  logic [CW-1:0]        rx_count;

  tx_state_e            tx_state_q, tx_state_d;
  logic [SBITS-1:0]     tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic tx_par_q, tx_par_d, tx_par_en_q, tx_par_en_d;
  logic tx_stop2_q, tx_stop2_d, tx_stop_n_q, tx_stop_n_d, txd_q, txd_d, tx_tick;

  rx_state_e            rx_state_q, rx_state_d;
  logic [SBITS-1:0]     rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half_q, rx_half_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  parity_e              rx_par_q, rx_par_d;
  logic rx_perr_q, rx_perr_d, rx_tick, rx_samp, rx_in;
  logic rxd_s1_q, rxd_s2_q, rx_prev_q;
  logic ov_set, pe_set, fe_set;
  logic unused_ok;

  assign unused_ok = ^{paddr, pwdata};
  assign pready    = 1'b1;
  assign access    = psel & penable;
  assign sel       = paddr[3:2];
  assign wr_data   = access & pwrite & (sel == REG_DATA);
  assign rd_data   = access & ~pwrite & (sel == REG_DATA);
  assign wr_status = access & pwrite & (sel == REG_STATUS);
  assign tx_push   = wr_data & ~tx_full;
  assign rx_pop    = rd_data & ~rx_empty;
  assign pslverr   = (wr_data & tx_full) | (rd_data & rx_empty);
  assign txd       = txd_q;
  assign irq       = irq_q;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .wdata(pwdata[DATA_BITS-1:0]),
    .pop(tx_pop), .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .wdata(rx_shift_q),
    .pop(rx_pop), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  always_comb begin
    status            = '0;
    status[ST_DR]     = ~rx_empty;
    status[ST_TS]     = (tx_state_q == TX_IDLE);
    status[ST_TE]     = tx_empty;
    status[ST_TF]     = tx_full;
    status[ST_RF]     = rx_full;
    status[ST_OV]     = ov_q;
    status[ST_PE]     = pe_q;
    status[ST_FE]     = fe_q;
    status[ST_RXCNT +: 8] = 8'(rx_count);
    status[ST_TXCNT +: 8] = 8'(tx_count);
    prdata = '0;
    case (sel)
      REG_DATA:   prdata = rx_empty ? '0 : 32'(rx_rdata);
      REG_STATUS: prdata = status;
      REG_CTRL:   prdata = 32'(ctrl_q);
      default:    prdata = 32'(scaler_q);
    endcase
  end

  // Hardware set wins over a same-cycle write-one-to-clear.
  always_comb begin
    ctrl_d   = ctrl_q;
    scaler_d = scaler_q;
    if (access && pwrite && sel == REG_CTRL)   ctrl_d   = pwdata[CTRL_W-1:0];
    if (access && pwrite && sel == REG_SCALER) scaler_d = pwdata[SBITS-1:0];
    ov_d = (ov_q & ~(wr_status & pwdata[ST_OV])) | ov_set;
    pe_d = (pe_q & ~(wr_status & pwdata[ST_PE])) | pe_set;
    fe_d = (fe_q & ~(wr_status & pwdata[ST_FE])) | fe_set;
    irq_d = (ctrl_q[CTRL_RIE] & ~rx_empty) | (ctrl_q[CTRL_TIE] & tx_empty) |
            (ctrl_q[CTRL_EIE] & (ov_q | pe_q | fe_q));
  end

  // Transmitter: frame format and bit period are captured at frame start.
  assign tx_tick = (tx_cnt_q == tx_div_q);

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_div_d    = tx_div_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_par_d    = tx_par_q;
    tx_par_en_d = tx_par_en_q;
    tx_stop2_d  = tx_stop2_q;
    tx_stop_n_d = tx_stop_n_q;
    tx_pop      = 1'b0;
    if (tx_state_q != TX_IDLE) tx_cnt_d = tx_tick ? '0 : tx_cnt_q + SBITS'(1);
    case (tx_state_q)
      TX_IDLE: begin
        if (ctrl_q[CTRL_TEN] && !tx_empty) begin
          tx_pop      = 1'b1;
          tx_state_d  = TX_START;
          tx_cnt_d    = '0;
          tx_div_d    = scaler_q;
          tx_shift_d  = tx_rdata;
          tx_par_en_d = par_enabled(parity_e'(ctrl_q[CTRL_PAR +: 2]));
          tx_par_d    = par_bit(parity_e'(ctrl_q[CTRL_PAR +: 2]), ^tx_rdata);
          tx_stop2_d  = ctrl_q[CTRL_STOP2];
        end
      end
      TX_START: if (tx_tick) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
      end
      TX_DATA: if (tx_tick) begin
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d   = tx_bit_q + 4'd1;
        if (tx_bit_q == LAST_BIT) begin
          tx_state_d  = tx_par_en_q ? TX_PARITY : TX_STOP;
          tx_stop_n_d = 1'b0;
        end
      end
      TX_PARITY: if (tx_tick) begin
        tx_state_d  = TX_STOP;
        tx_stop_n_d = 1'b0;
      end
      TX_STOP: if (tx_tick) begin
        if (tx_stop2_q && !tx_stop_n_q) tx_stop_n_d = 1'b1;
        else                            tx_state_d  = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    case (tx_state_d)
      TX_START:  txd_d = 1'b0;
      TX_DATA:   txd_d = tx_shift_d[0];
      TX_PARITY: txd_d = tx_par_d;
      default:   txd_d = 1'b1;
    endcase
  end

  // Receiver: sample point is counted from the first synchronised low cycle.
  assign rx_in   = rxd_s2_q;
  assign rx_tick = (rx_cnt_q == rx_div_q);
  assign rx_samp = (rx_cnt_q == rx_half_q);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_half_d  = rx_half_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_perr_d  = rx_perr_q;
    rx_push    = 1'b0;
    ov_set     = 1'b0;
    pe_set     = 1'b0;
    fe_set     = 1'b0;
    if (rx_state_q != RX_IDLE) rx_cnt_d = rx_tick ? '0 : rx_cnt_q + SBITS'(1);
    case (rx_state_q)
      RX_IDLE: begin
        if (ctrl_q[CTRL_RE] && rx_prev_q && !rx_in) begin
          rx_div_d  = scaler_q;
          rx_half_d = SBITS'(({1'b0, scaler_q} + {{SBITS{1'b0}}, 1'b1}) >> 1);
          rx_par_d  = parity_e'(ctrl_q[CTRL_PAR +: 2]);
          rx_perr_d = 1'b0;
          rx_bit_d  = '0;
          // With one cycle per bit the start bit was already sampled low here.
          if (scaler_q == '0) begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = '0;
          end else begin
            rx_state_d = RX_START;
            rx_cnt_d   = SBITS'(1);
          end
        end
      end
      RX_START: begin
        if (rx_samp && rx_in) rx_state_d = RX_IDLE;
        else if (rx_tick) begin
          rx_state_d = RX_DATA;
          rx_bit_d   = '0;
        end
      end
      RX_DATA: begin
        if (rx_samp) rx_shift_d = {rx_in, rx_shift_q[DATA_BITS-1:1]};
        if (rx_tick) begin
          rx_bit_d = rx_bit_q + 4'd1;
          if (rx_bit_q == LAST_BIT) rx_state_d = par_enabled(rx_par_q) ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (rx_samp) rx_perr_d = (rx_in != par_bit(rx_par_q, ^rx_shift_q));
        if (rx_tick) rx_state_d = RX_STOP;
      end
      RX_STOP: begin
        if (rx_samp) begin
          rx_push    = ~rx_full;
          ov_set     = rx_full;
          fe_set     = ~rx_in;
          pe_set     = rx_perr_q;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (!ctrl_q[CTRL_RE] && rx_state_q != RX_IDLE) begin
      rx_state_d = RX_IDLE;
      rx_push    = 1'b0;
      ov_set     = 1'b0;
      pe_set     = 1'b0;
      fe_set     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q      <= '0;
      scaler_q    <= SCALER_RST;
      ov_q        <= 1'b0;
      pe_q        <= 1'b0;
      fe_q        <= 1'b0;
      irq_q       <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_div_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_par_q    <= 1'b0;
      tx_par_en_q <= 1'b0;
      tx_stop2_q  <= 1'b0;
      tx_stop_n_q <= 1'b0;
      txd_q       <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_div_q    <= '0;
      rx_half_q   <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_par_q    <= PAR_NONE;
      rx_perr_q   <= 1'b0;
      rxd_s1_q    <= 1'b1;
      rxd_s2_q    <= 1'b1;
      rx_prev_q   <= 1'b1;
    end else begin
      ctrl_q      <= ctrl_d;
      scaler_q    <= scaler_d;
      ov_q        <= ov_d;
      pe_q        <= pe_d;
      fe_q        <= fe_d;
      irq_q       <= irq_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_div_q    <= tx_div_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_par_q    <= tx_par_d;
      tx_par_en_q <= tx_par_en_d;
      tx_stop2_q  <= tx_stop2_d;
      tx_stop_n_q <= tx_stop_n_d;
      txd_q       <= txd_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_div_q    <= rx_div_d;
      rx_half_q   <= rx_half_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_par_q    <= rx_par_d;
      rx_perr_q   <= rx_perr_d;
      rxd_s1_q    <= ctrl_q[CTRL_LB] ? txd_q : rxd;
      rxd_s2_q    <= rxd_s1_q;
      rx_prev_q   <= rxd_s2_q;
    end
  end

endmodule

// File: tb/tb_apb_uart_ng.sv
// Directed-plus-random bench for apb_uart_ng: expected serial frames and
// register values come from a frame builder and a character queue.
module tb_apb_uart_ng;
  localparam int DB = 8;
  localparam int FD = 16;

  logic        clk = 1'b0;
  logic        rst, psel, penable, pwrite, rxd;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr, txd, irq;

  int checks = 0;
  int errors = 0;
  bit          frame_q[$];
  logic [DB-1:0] exp_q[$];

  always #5 clk = ~clk;

  apb_uart_ng #(.DATA_BITS(DB), .FIFO_DEPTH(FD), .SBITS(12), .ABITS(8), .SCALER_RST(12'd867)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .rxd(rxd), .txd(txd), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    #1 err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] a, output logic [31:0] d, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    #1 begin d = prdata; err = pslverr; end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Line-level picture of one character: start, data LSB first, parity, stop(s).
  function automatic void build_frame(input logic [DB-1:0] ch, input int par, input bit two);
    int ones;
    frame_q.delete();
    frame_q.push_back(1'b0);
    for (int i = 0; i < DB; i++) frame_q.push_back(ch[i]);
    ones = $countones(ch);
    if (par == 1) frame_q.push_back((ones % 2) == 1);
    else if (par == 2) frame_q.push_back((ones % 2) == 0);
    frame_q.push_back(1'b1);
    if (two) frame_q.push_back(1'b1);
  endfunction

  task automatic wait_txd_low(input string tag, output bit found);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk); #1;
      if (txd === 1'b0) found = 1'b1;
    end
    chk({tag, "_start"}, 32'(found), 32'd1);
  endtask

  task automatic check_tx_stream(input string tag, input int div);
    bit found;
    int s;
    s = div + 1;
    wait_txd_low(tag, found);
    if (found) begin
      cyc(s / 2);
      for (int i = 0; i < frame_q.size(); i++) begin
        chk($sformatf("%s_bit%0d", tag, i), 32'(txd), 32'(frame_q[i]));
        if (i != frame_q.size() - 1) cyc(s);
      end
    end
  endtask

  task automatic drive_frame(input int div);
    for (int i = 0; i < frame_q.size(); i++) begin
      rxd = frame_q[i];
      cyc(div + 1);
    end
    rxd = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    logic [DB-1:0] ch;
    int div, par;
    bit two, found;

    rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; rxd = 1'b1;
    cyc(3);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    paddr = 8'h0C; #1 chk("rst_scaler", prdata, 32'd867);
    paddr = 8'h04; #1 chk("rst_status", prdata, 32'h6);
    paddr = 8'h08; #1 chk("rst_ctrl", prdata, 32'h0);
    rst = 1'b1;
    cyc(2);

    // Fixed 0x55 frame at four cycles per bit.
    apb_wr(8'h0C, 32'd3, e);
    apb_wr(8'h08, 32'h3, e);
    apb_wr(8'h00, 32'h55, e);
    chk("fix55_err", 32'(e), 32'd0);
    build_frame(8'h55, 0, 1'b0);
    check_tx_stream("fix55", 3);
    cyc(8);
    apb_rd(8'h04, d, e);
    chk("fix55_status", d, 32'h6);
    apb_wr(8'h08, 32'h43, e);
    cyc(2);
    chk("tie_irq_on", 32'(irq), 32'd1);
    apb_wr(8'h08, 32'h03, e);
    cyc(2);
    chk("tie_irq_off", 32'(irq), 32'd0);

    // Loopback with random formats; pass 1 is even parity with 0xA7.
    for (int k = 0; k < 6; k++) begin
      div = (k == 0) ? 0 : $urandom_range(0, 4);
      par = (k == 1) ? 1 : $urandom_range(0, 3);
      two = 1'($urandom_range(0, 1));
      ch  = (k == 1) ? 8'hA7 : DB'($urandom);
      apb_wr(8'h0C, 32'(div), e);
      apb_wr(8'h08, 32'h103 | (32'(par) << 2) | (32'(two) << 4), e);
      apb_wr(8'h00, 32'(ch), e);
      build_frame(ch, par, two);
      check_tx_stream($sformatf("lb%0d", k), div);
      cyc(3 * (div + 1) + 6);
      apb_rd(8'h04, d, e);
      chk($sformatf("lb%0d_status", k), d, 32'h107);
      apb_rd(8'h00, d, e);
      chk($sformatf("lb%0d_data", k), d, 32'(ch));
      chk($sformatf("lb%0d_err", k), 32'(e), 32'd0);
    end
    apb_wr(8'h08, 32'h0, e);

    // Odd-parity frame with a zero stop bit into an even-parity receiver.
    apb_wr(8'h0C, 32'd3, e);
    apb_wr(8'h08, 32'h85, e);
    ch = DB'($urandom);
    build_frame(ch, 2, 1'b0);
    frame_q[frame_q.size() - 1] = 1'b0;
    drive_frame(3);
    cyc(6);
    apb_rd(8'h04, d, e);
    chk("pefe_status", d, 32'h1C7);
    chk("pefe_irq", 32'(irq), 32'd1);
    apb_rd(8'h00, d, e);
    chk("pefe_data", d, 32'(ch));
    apb_wr(8'h04, 32'hC0, e);
    apb_rd(8'h04, d, e);
    chk("pefe_clear", d, 32'h6);
    cyc(2);
    chk("pefe_irq_off", 32'(irq), 32'd0);

    // Overflow: one frame more than the RX FIFO holds, no reads.
    apb_wr(8'h0C, 32'd1, e);
    apb_wr(8'h08, 32'h1, e);
    exp_q.delete();
    for (int f = 0; f < FD + 1; f++) begin
      ch = DB'($urandom);
      if (f < FD) exp_q.push_back(ch);
      build_frame(ch, 0, 1'b0);
      drive_frame(1);
      cyc(2);
    end
    cyc(6);
    apb_rd(8'h04, d, e);
    chk("ovf_status", d, 32'h1037);
    for (int i = 0; i < FD; i++) begin
      apb_rd(8'h00, d, e);
      chk($sformatf("ovf_data%0d", i), d, 32'(exp_q.pop_front()));
    end
    apb_rd(8'h04, d, e);
    chk("ovf_sticky", d, 32'h26);
    apb_wr(8'h04, 32'h20, e);
    apb_rd(8'h04, d, e);
    chk("ovf_clear", d, 32'h6);

    // TX FIFO fill with transmitter disabled, then read of empty RX FIFO.
    apb_wr(8'h08, 32'h0, e);
    for (int i = 0; i < FD + 1; i++) begin
      apb_wr(8'h00, $urandom, e);
      chk($sformatf("txfull_err%0d", i), 32'(e), 32'(i == FD));
    end
    apb_rd(8'h04, d, e);
    chk("txfull_status", d, 32'h0010000A);
    apb_rd(8'h00, d, e);
    chk("rxempty_data", d, 32'h0);
    chk("rxempty_err", 32'(e), 32'd1);

    // Reset in the middle of a transmitted frame.
    apb_wr(8'h0C, 32'd3, e);
    apb_wr(8'h08, 32'h2, e);
    wait_txd_low("midrst", found);
    cyc(6);
    #3 rst = 1'b0;
    #1 chk("midrst_txd", 32'(txd), 32'd1);
    chk("midrst_irq", 32'(irq), 32'd0);
    paddr = 8'h0C; #1 chk("midrst_scaler", prdata, 32'd867);
    paddr = 8'h04; #1 chk("midrst_status", prdata, 32'h6);
    paddr = 8'h08; #1 chk("midrst_ctrl", prdata, 32'h0);
    @(posedge clk); #2 rst = 1'b1;
    cyc(2);
    apb_rd(8'h04, d, e);
    chk("postrst_status", d, 32'h6);
    cyc(20);
    chk("postrst_txd", 32'(txd), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
